cska_mp_sequencer: RTL and testbench



---
 rtl/cska_mp_sequencer_if.sv | 30 +++
 rtl/cska_mp_sequencer.sv | 140 ++++++++++++++
 tb/tb_cska_mp_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cska_mp_sequencer_if.sv
// Handshake and operand/result bus between an operand source/result consumer
// and the multi-precision add/subtract sequencer.
interface cska_mp_sequencer_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = N * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, busy
    );
endinterface

// File: rtl/cska_mp_sequencer.sv
// Multi-precision add/subtract sequencer: one N-bit carry-skip adder is reused
// once per word, LSW first, with the carry chained through a register.

module cska_top #(
    parameter int unsigned N          = 16,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    localparam int unsigned NBLK = N / BLOCK_SIZE;

    // Each block ripples internally; a fully propagating block passes its
    // carry-in straight through the skip mux.
    always_comb begin
        logic c;
        logic cb;
        logic p;
        logic x;
        sum_o = '0;
        c     = cin_i;
        cb    = 1'b0;
        p     = 1'b0;
        x     = 1'b0;
        for (int unsigned blk = 0; blk < NBLK; blk++) begin
            cb = c;
            p  = 1'b1;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
                x = a_i[blk*BLOCK_SIZE+i] ^ b_i[blk*BLOCK_SIZE+i];
                sum_o[blk*BLOCK_SIZE+i] = x ^ cb;
                p  = p & x;
                cb = (a_i[blk*BLOCK_SIZE+i] & b_i[blk*BLOCK_SIZE+i]) | (cb & x);
            end
            c = p ? c : cb;
        end
        cout_o = c;
    end
endmodule

module cska_mp_sequencer #(
    parameter int unsigned N          = 16,
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned WORDS      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cska_mp_sequencer_if.slave   bus
);
    localparam int unsigned W  = N * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    result_q;
    logic [KW-1:0]   k_q;
    logic            carry_q;
    logic            cout_q;
    logic            ovf_q;

    logic [N-1:0]    add_a;
    logic [N-1:0]    add_b;
    logic [N-1:0]    add_sum;
    logic            add_cout;
    logic            last_word;

    assign add_a     = a_q[k_q*N +: N];
    assign add_b     = b_q[k_q*N +: N];
    assign last_word = (k_q == KW'(WORDS - 1));

    cska_top #(
        .N          (N),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry_q <= bus.sub;
                        k_q     <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q[k_q*N +: N] <= add_sum;
                    carry_q              <= add_cout;
                    if (last_word) begin
                        cout_q  <= add_cout;
                        // b_q already holds the effective (possibly inverted) operand
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
                        state_q <= S_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cska_mp_sequencer.sv
// Bench for cska_mp_sequencer: directed operations checked against hand
// values and against a cycle-level transaction model on every cycle.
module tb_cska_mp_sequencer;
    localparam int unsigned N     = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cska_mp_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

    cska_mp_sequencer #(
        .N          (N),
        .BLOCK_SIZE (4),
        .WORDS      (WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction model: an accepted op becomes visible WORDS edges later.
    logic         m_busy  = 1'b0;
    logic         m_valid = 1'b0;
    int           m_age   = 0;
    logic [W-1:0] m_res   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         chk_en  = 1'b0;

    always @(posedge clk) begin
        logic [W:0]   full;
        logic [W-1:0] beff;
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_age   = 0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                beff    = bus.sub ? ~bus.op_b : bus.op_b;
                full    = {1'b0, bus.op_a} + {1'b0, beff} + {{W{1'b0}}, bus.sub};
                m_res   = full[W-1:0];
                m_cout  = full[W];
                m_ovf   = (bus.op_a[W-1] == beff[W-1]) && (full[W-1] != bus.op_a[W-1]);
                m_busy  = 1'b1;
                m_age   = 0;
            end
        end else if (!m_valid) begin
            m_age++;
            if (m_age == int'(WORDS)) m_valid = 1'b1;
        end else if (bus.out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", W'(bus.in_ready), W'(!m_busy && !rst));
            check("busy", W'(bus.busy), W'(m_busy));
            check("out_valid", W'(bus.out_valid), W'(m_valid));
            if (m_valid) begin
                check("model_result", bus.result, m_res);
                check("model_carry", W'(bus.carry_out), W'(m_cout));
                check("model_overflow", W'(bus.overflow), W'(m_ovf));
            end
        end
    end

    task automatic wait_valid(input string name);
        int lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, W'(lat), W'(WORDS));
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] er, input logic ec, input logic eo);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid(name);
        check({name, "_result"}, bus.result, er);
        check({name, "_carry"}, W'(bus.carry_out), W'(ec));
        check({name, "_overflow"}, W'(bus.overflow), W'(eo));
        check({name, "_model_pin"}, m_res, er);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.op_a      = 64'd1;
        bus.op_b      = 64'd1;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("reset_result", bus.result, '0);
        check("reset_in_ready", W'(bus.in_ready), '0);
        @(posedge clk); #1;
        check("reset_busy_with_in_valid", W'(bus.busy), '0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("in_ready_after_reset", W'(bus.in_ready), W'(1));

        run_op("add_cross_word", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0);
        run_op("add_skip_chain", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5556, 1'b0,
               64'h0, 1'b1, 1'b0);
        run_op("add_signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 64'h2, 1'b1, 1'b0);
        run_op("sub_min_1", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Backpressure: hold DONE while a new op waits on in_valid.
        bus.in_valid = 1'b1;
        bus.op_a     = 64'h7FFF_FFFF_FFFF_FFFF;
        bus.op_b     = 64'h1;
        bus.sub      = 1'b0;
        @(posedge clk); #1;
        bus.op_a = 64'd3;
        bus.op_b = 64'd4;
        wait_valid("bp_first");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_result", bus.result, 64'h8000_0000_0000_0000);
            check("bp_hold_overflow", W'(bus.overflow), W'(1));
            check("bp_hold_in_ready", W'(bus.in_ready), '0);
            check("bp_hold_valid", W'(bus.out_valid), W'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_idle", W'(bus.in_ready), W'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid("bp_second");
        check("bp_second_result", bus.result, 64'd7);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset abort while the third word (k=2) is being added.
        bus.in_valid = 1'b1;
        bus.op_a     = 64'h1234_5678_9ABC_DEF0;
        bus.op_b     = 64'h1111_1111_1111_1111;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", W'(bus.out_valid), '0);
        check("abort_result", bus.result, '0);
        check("abort_busy", W'(bus.busy), '0);
        run_op("after_abort", 64'd1, 64'd1, 1'b0, 64'h2, 1'b0, 1'b0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
